segasys1_sound_latch: RTL and testbench

//  Command mailbox between the main Z80 and the sound Z80. Captures the byte the

---
 rtl/segasys1_sound_latch_if.sv | 18 +
 rtl/segasys1_sound_latch.sv | 78 +++++++
 tb/tb_segasys1_sound_latch.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/segasys1_sound_latch_if.sv
// segasys1_sound_latch_if: main-CPU write strobe, sound-CPU read strobe and mailbox status bundle
interface segasys1_sound_latch_if #(parameter int DEPTH = 4);
  localparam int LW = $clog2(DEPTH) + 1;
  logic          wr_req;
  logic [7:0]    wr_data;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          snd_nmi;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          ovf;
  logic          ovf_clr;
  modport master (output wr_req, wr_data, rd_req, ovf_clr,
                  input  rd_data, snd_nmi, empty, full, level, ovf);
  modport slave  (input  wr_req, wr_data, rd_req, ovf_clr,
                  output rd_data, snd_nmi, empty, full, level, ovf);
endinterface

// File: rtl/segasys1_sound_latch.sv
// segasys1_sound_latch: main-to-sound Z80 command FIFO with NMI pacing
module segasys1_sound_latch #(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 96
) (
  input  logic CLK48M,
  input  logic RESET,
  segasys1_sound_latch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(GAP_CYC + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_n;
  logic          empty, full, ovf, snd_nmi;
  logic [7:0]    rd_data;
  logic          wr_q, rd_q, live, pop_q;
  logic          push, pop, do_push, do_pop;
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt;
  // live blocks a strobe that was already high across reset from looking like a new edge
  assign push    = bus.wr_req & ~wr_q & live;
  assign pop     = ~bus.rd_req & rd_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level_n = level + LW'(do_push) - LW'(do_pop);
  // the NMI drops one edge after the pop via pop_q
  always_comb
    state_n = state == IDLE   ? (empty ? IDLE : ASSERT) :
              state == ASSERT ? (pop_q ? GAP : ASSERT) :
                                (cnt == '0 ? IDLE : GAP);
  always_ff @(posedge CLK48M)
    if (do_push) mem[wr_ptr] <= bus.wr_data;
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      ovf     <= 1'b0;
      rd_data <= 8'h00;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      live    <= 1'b0;
      pop_q   <= 1'b0;
      state   <= IDLE;
      snd_nmi <= 1'b0;
      cnt     <= '0;
    end else begin
      wr_q    <= bus.wr_req;
      rd_q    <= bus.rd_req;
      live    <= 1'b1;
      pop_q   <= do_pop;
      wr_ptr  <= wr_ptr + AW'(do_push);
      rd_ptr  <= rd_ptr + AW'(do_pop);
      level   <= level_n;
      empty   <= level_n == '0;
      full    <= level_n == LW'(DEPTH);
      rd_data <= empty ? rd_data : mem[rd_ptr];
      ovf     <= (push & full & ~pop) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf;
      state   <= state_n;
      snd_nmi <= state_n == ASSERT;
      cnt     <= (state == ASSERT && pop_q) ? CW'(GAP_CYC - 1) :
                 (state == GAP && cnt != '0) ? cnt - 1'b1 : cnt;
    end
  end
  assign bus.rd_data = rd_data;
  assign bus.snd_nmi = snd_nmi;
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.level   = level;
  assign bus.ovf     = ovf;
endmodule

// File: tb/tb_segasys1_sound_latch.sv
// tb_segasys1_sound_latch: directed checks of FIFO, overflow, NMI pacing and reset
module tb_segasys1_sound_latch;
  logic CLK48M = 1'b0;
  logic RESET  = 1'b1;
  int checks = 0;
  int errors = 0;
  int n;
  segasys1_sound_latch_if #(.DEPTH(4)) bus ();
  segasys1_sound_latch #(.DEPTH(4), .GAP_CYC(96)) dut (.CLK48M(CLK48M), .RESET(RESET), .bus(bus));
  always #5 CLK48M = ~CLK48M;
  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK48M);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wr(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_req  = 1'b1;
    step(2);
    bus.wr_req  = 1'b0;
    step(1);
  endtask
  task automatic rd(input string tag, input logic [7:0] e);
    bus.rd_req = 1'b1;
    step(2);
    chk(tag, bus.rd_data, e);
    bus.rd_req = 1'b0;
    step(2);
  endtask
  task automatic wait_nmi(output int cyc);
    cyc = 0;
    while (bus.snd_nmi !== 1'b1 && cyc < 300) begin
      step(1);
      cyc++;
    end
  endtask
  initial begin
    bus.wr_req = 1'b0; bus.wr_data = 8'h00; bus.rd_req = 1'b0; bus.ovf_clr = 1'b0;
    step(2);
    chk("rst_level", bus.level, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_nmi", bus.snd_nmi, 0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    RESET = 1'b0;
    step(2);
    // 1: single 4-cycle write
    bus.wr_data = 8'h5A;
    bus.wr_req  = 1'b1;
    step(1);
    chk("t1_level_k", bus.level, 1);
    chk("t1_empty_k", bus.empty, 0);
    chk("t1_nmi_k", bus.snd_nmi, 0);
    step(1);
    chk("t1_nmi_k1", bus.snd_nmi, 1);
    chk("t1_rd_data", bus.rd_data, 8'h5A);
    step(2);
    bus.wr_req = 1'b0;
    step(2);
    chk("t1_level_hold", bus.level, 1);
    // 2: one 6-cycle read pops exactly once
    bus.rd_req = 1'b1;
    step(6);
    chk("t2_level_during", bus.level, 1);
    bus.rd_req = 1'b0;
    step(1);
    chk("t2_level", bus.level, 0);
    chk("t2_empty", bus.empty, 1);
    chk("t2_nmi_p", bus.snd_nmi, 1);
    step(1);
    chk("t2_nmi_p1", bus.snd_nmi, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (bus.snd_nmi !== 1'b0) n++;
    end
    chk("t2_nmi_low", n, 0);
    chk("t2_rd_hold", bus.rd_data, 8'h5A);
    // 3: overflow then drain in order
    for (int i = 1; i <= 5; i++) wr(8'(i));
    chk("t3_full", bus.full, 1);
    chk("t3_level", bus.level, 4);
    chk("t3_ovf", bus.ovf, 1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr", bus.ovf, 0);
    rd("t3_rd1", 8'h01);
    rd("t3_rd2", 8'h02);
    rd("t3_rd3", 8'h03);
    rd("t3_rd4", 8'h04);
    chk("t3_empty", bus.empty, 1);
    // 4: push and pop on the same edge while full
    for (int i = 0; i < 4; i++) wr(8'h11 + 8'(i));
    chk("t4_full", bus.full, 1);
    bus.rd_req = 1'b1;
    step(2);
    chk("t4_head", bus.rd_data, 8'h11);
    bus.rd_req  = 1'b0;
    bus.wr_data = 8'h15;
    bus.wr_req  = 1'b1;
    step(1);
    chk("t4_level", bus.level, 4);
    chk("t4_ovf", bus.ovf, 0);
    bus.wr_req = 1'b0;
    step(2);
    rd("t4_rd1", 8'h12);
    rd("t4_rd2", 8'h13);
    rd("t4_rd3", 8'h14);
    rd("t4_rd4", 8'h15);
    rd("t4_rd_empty", 8'h15);
    chk("t4_level_empty", bus.level, 0);
    // 5: three entries produce three paced NMI pulses
    step(120);
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    wait_nmi(n);
    chk("t5_nmi_first", bus.snd_nmi, 1);
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1'b1;
      step(2);
      chk("t5_rd_data", bus.rd_data, 8'hA1 + 8'(i));
      bus.rd_req = 1'b0;
      step(1);
      chk("t5_nmi_p", bus.snd_nmi, 1);
      step(1);
      chk("t5_nmi_p1", bus.snd_nmi, 0);
      wait_nmi(n);
      chk("t5_gap", n, i < 2 ? 97 : 300);
    end
    // 6: asynchronous reset mid-ASSERT with two entries
    wr(8'hB1);
    bus.wr_data = 8'hB2;
    bus.wr_req  = 1'b1;
    step(1);
    chk("t6_level", bus.level, 2);
    chk("t6_nmi", bus.snd_nmi, 1);
    #2 RESET = 1'b1;
    #1;
    chk("t6_rst_nmi", bus.snd_nmi, 0);
    chk("t6_rst_empty", bus.empty, 1);
    chk("t6_rst_level", bus.level, 0);
    step(2);
    RESET = 1'b0;
    step(3);
    chk("t6_no_push", bus.level, 0);
    bus.wr_req = 1'b0;
    step(1);
    bus.wr_data = 8'hC3;
    bus.wr_req  = 1'b1;
    step(2);
    chk("t6_repush", bus.level, 1);
    chk("t6_repush_data", bus.rd_data, 8'hC3);
    bus.wr_req = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
